// File: rtl/ibex_ex_fault_ctrl.sv
// Retry/escalation controller for an M-of-N monitored EX-stage ALU.
// Gates EX valid towards ID, replays an instruction a bounded number of
// times after a no-majority error, then latches a fatal alert.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | normal operation, results pass through
// S_WAIT   | letting the monitor hold window drain before a replay
// S_REPLAY | one-cycle replay request to ID
// S_CHECK  | waiting for the replayed result
// S_FATAL  | retries exhausted; sticky major alert until CSR clear
module ibex_ex_fault_ctrl #(
  parameter int unsigned MaxRetries = 2,
  parameter int unsigned RetryDelay = 1,
  parameter int unsigned CntW       = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic            min_err_i,
  input  logic            maj_err_i,
  input  logic            clear_i,
  output logic            ex_valid_o,
  output logic            replay_o,
  output logic            busy_o,
  output logic            alert_minor_o,
  output logic            alert_major_o,
  output logic [CntW-1:0] min_err_cnt_o,
  output logic [CntW-1:0] maj_err_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REPLAY,
    S_CHECK,
    S_FATAL
  } state_e;

  localparam logic [3:0] RetryDelayL = 4'(RetryDelay);
  localparam logic [3:0] MaxRetriesL = 4'(MaxRetries);

  state_e          state_q, state_d;
  logic [3:0]      delay_q, delay_d;
  logic [3:0]      retry_q, retry_d;
  logic [CntW-1:0] min_cnt_q, maj_cnt_q;
  logic            pass_window;
  logic            maj_hit, min_hit;

  // Results (and error flags) are only meaningful while EX is not being replayed.
  assign pass_window = (state_q == S_IDLE) || (state_q == S_CHECK);
  assign maj_hit     = pass_window & ex_valid_i & maj_err_i;
  assign min_hit     = pass_window & ex_valid_i & min_err_i & ~maj_err_i;

  assign ex_valid_o    = pass_window & ex_valid_i & ~maj_err_i;
  assign busy_o        = (state_q != S_IDLE);
  assign alert_major_o = (state_q == S_FATAL);
  // A minor error swallowed by a same-cycle clear is not counted, so no pulse.
  assign alert_minor_o = min_hit & ~clear_i;
  assign min_err_cnt_o = min_cnt_q;
  assign maj_err_cnt_o = maj_cnt_q;

  // State, delay timer and retry counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic and replay request.
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    retry_d  = retry_q;
    replay_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid_i && maj_err_i) begin
          state_d = S_WAIT;
          delay_d = RetryDelayL;
        end
      end
      S_WAIT: begin
        if (delay_q <= 4'd1) begin
          state_d = S_REPLAY;
          delay_d = '0;
        end else begin
          delay_d = delay_q - 4'd1;
        end
      end
      S_REPLAY: begin
        replay_o = 1'b1;
        retry_d  = retry_q + 4'd1;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (ex_valid_i) begin
          if (!maj_err_i) begin
            retry_d = '0;
            state_d = S_IDLE;
          end else if (retry_q < MaxRetriesL) begin
            state_d = S_WAIT;
            delay_d = RetryDelayL;
          end else begin
            state_d = S_FATAL;
          end
        end
      end
      S_FATAL: begin
        if (clear_i) begin
          retry_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating error counters; a CSR clear wins over same-cycle increments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_cnt_q <= '0;
      maj_cnt_q <= '0;
    end else if (clear_i) begin
      min_cnt_q <= '0;
      maj_cnt_q <= '0;
    end else begin
      if (maj_hit && (maj_cnt_q != {CntW{1'b1}})) maj_cnt_q <= maj_cnt_q + CntW'(1);
      if (min_hit && (min_cnt_q != {CntW{1'b1}})) min_cnt_q <= min_cnt_q + CntW'(1);
    end
  end

endmodule
